// File: rtl/upmod12_arb_ctrl.sv
// Round-robin arbiter that lends one upmod12 counter to two requesters,
// loading the granted start value and reporting completion or counter fault.
module upmod12_arb_ctrl #(
  parameter int W    = 4,
  parameter int TERM = 11,
  parameter int MOD  = 12,
  parameter int WDOG = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] start0,
  input  logic [W-1:0] start1,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic         err,
  output logic         busy,
  output logic         cnt_load,
  output logic [W-1:0] cnt_a,
  input  logic [W-1:0] cnt_count
);

  // state | meaning
  // IDLE  | no owner; arbitrate among pending requests
  // LOAD  | one cycle driving the captured start value into the counter
  // RUN   | counter running; watch for terminal count, abort or watchdog
  // DONE  | one-cycle done/err pulse to the owner, then hand priority over
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int WD = (WDOG > 1) ? $clog2(WDOG) : 1;
  localparam logic [W-1:0]  TERM_W    = W'(TERM);
  localparam logic [WD-1:0] WDOG_LAST = WD'(WDOG - 1);

  logic [1:0]    state;
  logic          id;
  logic          rr;
  logic          flag;
  logic [W-1:0]  val;
  logic [WD-1:0] wdog;

  logic          sel;
  logic [W-1:0]  sel_val;
  logic          sel_bad;
  logic [1:0]    id_oh;

  always_comb begin
    sel     = (req == 2'b11) ? rr : req[1];
    sel_val = sel ? start1 : start0;
    sel_bad = (32'(sel_val) >= 32'(MOD));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      id    <= 1'b0;
      rr    <= 1'b0;
      flag  <= 1'b0;
      val   <= '0;
      wdog  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req != 2'b00) begin
            id    <= sel;
            val   <= sel_val;
            flag  <= sel_bad;
            // an out-of-range start never touches the counter
            state <= sel_bad ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          wdog  <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          wdog <= wdog + 1'b1;
          if (!req[id]) begin
            state <= S_IDLE;
          end else if (cnt_count == TERM_W) begin
            flag  <= 1'b0;
            state <= S_DONE;
          end else if (wdog == WDOG_LAST) begin
            flag  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          rr    <= ~id;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    id_oh    = {id, ~id};
    busy     = (state != S_IDLE);
    cnt_load = (state == S_LOAD);
    cnt_a    = cnt_load ? val : '0;
    gnt      = busy ? id_oh : 2'b00;
    done     = (state == S_DONE) ? id_oh : 2'b00;
    err      = (state == S_DONE) && flag;
  end

endmodule

// File: tb/tb_upmod12_arb_ctrl.sv
// Bench for upmod12_arb_ctrl: emulated counter, interval-level reference
// model checked every cycle, plus directed scenarios with literal latencies.
module tb_upmod12_arb_ctrl;
  localparam int W = 4, TERM = 11, MOD = 12, WDOG = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] start0 = '0, start1 = '0;
  logic [W-1:0] cnt_count = '0;
  logic [1:0]   gnt, done;
  logic         err, busy, cnt_load;
  logic [W-1:0] cnt_a;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  bit stuck = 0;

  always #5 clk = ~clk;

  upmod12_arb_ctrl #(.W(W), .TERM(TERM), .MOD(MOD), .WDOG(WDOG)) dut (
    .clk(clk), .rst(rst), .req(req), .start0(start0), .start1(start1),
    .gnt(gnt), .done(done), .err(err), .busy(busy),
    .cnt_load(cnt_load), .cnt_a(cnt_a), .cnt_count(cnt_count)
  );

  // upmod12 counter; 'stuck' emulates a broken counter frozen at 5
  always @(posedge clk) begin
    if (stuck) cnt_count <= 4'd5;
    else if (cnt_load) cnt_count <= cnt_a;
    else cnt_count <= (int'(cnt_count) == MOD - 1) ? '0 : cnt_count + 1'b1;
  end

  // Reference: one interval = grant, age counts edges since grant,
  // m_end marks the completion cycle (1 ok, 2 error).
  bit m_act;
  int m_id, m_v, m_age, m_end, m_rr;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act = 0; m_id = 0; m_v = 0; m_age = 0; m_end = 0; m_rr = 0;
    end else if (m_end != 0) begin
      m_act = 0; m_end = 0; m_rr = 1 - m_id;
    end else if (m_act) begin
      if (m_age == 1) m_age = 2;
      else if (!req[m_id]) m_act = 0;
      else if (int'(cnt_count) == TERM) m_end = 1;
      else if (m_age - 2 == WDOG - 1) m_end = 2;
      else m_age++;
    end else if (req != 2'b00) begin
      m_id  = (req == 2'b11) ? m_rr : (req[1] ? 1 : 0);
      m_v   = m_id ? int'(start1) : int'(start0);
      m_act = 1;
      m_age = 1;
      if (m_v >= MOD) m_end = 2;
    end
  end

  task automatic check_outputs(input string tag);
    logic [1:0] e_gnt, e_done;
    logic e_err, e_busy, e_load;
    logic [W-1:0] e_a;
    e_gnt  = m_act ? (2'b01 << m_id) : 2'b00;
    e_done = (m_act && m_end != 0) ? (2'b01 << m_id) : 2'b00;
    e_err  = m_act && m_end == 2;
    e_busy = m_act;
    e_load = m_act && m_age == 1 && m_end == 0;
    e_a    = e_load ? W'(m_v) : '0;
    n_cmp++;
    if ({gnt, done, err, busy, cnt_load, cnt_a} !== {e_gnt, e_done, e_err, e_busy, e_load, e_a}) begin
      n_bad++;
      $display("FAIL %s t=%0t got gnt=%b done=%b err=%b busy=%b load=%b a=%0d want gnt=%b done=%b err=%b busy=%b load=%b a=%0d",
               tag, $time, gnt, done, err, busy, cnt_load, cnt_a,
               e_gnt, e_done, e_err, e_busy, e_load, e_a);
    end
  endtask

  always @(negedge clk) if (chk_en) check_outputs("cycle");

  task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n = index of the edge after which done was first seen (first edge is 0)
  task automatic wait_done(input int bound, output int n, output logic [1:0] d, output logic e);
    bit seen;
    seen = 0; n = -1; d = 2'b00; e = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (done != 2'b00) begin
        seen = 1; n = i; d = done; e = err;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  int n;
  logic [1:0] d;
  logic e;

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    tick();
    chk_en = 1;
    expect_val("rst_gnt", 32'(gnt), 0);
    expect_val("rst_busy", 32'(busy), 0);
    expect_val("rst_cnt_a", 32'(cnt_a), 0);
    rst = 1'b1;
    tick();

    // single requester, start 0: LOAD after E0, done after E13
    start0 = 4'd0; req = 2'b01;
    tick();
    expect_val("t1_gnt", 32'(gnt), 1);
    expect_val("t1_load", 32'(cnt_load), 1);
    wait_done(30, n, d, e);
    expect_val("t1_done_edge", n + 1, 13);
    expect_val("t1_done", 32'(d), 1);
    expect_val("t1_err", 32'(e), 0);
    req = 2'b00;
    tick();
    expect_val("t1_busy_after", 32'(busy), 0);

    // both requesting after reset: 0, then 1, then 0 again
    do_reset();
    start0 = 4'd9; start1 = 4'd10; req = 2'b11;
    wait_done(20, n, d, e);
    expect_val("t2a_edge", n, 4);
    expect_val("t2a_done", 32'(d), 1);
    wait_done(20, n, d, e);
    expect_val("t2b_edge", n, 4);
    expect_val("t2b_done", 32'(d), 2);
    wait_done(20, n, d, e);
    expect_val("t2c_edge", n, 5);
    expect_val("t2c_done", 32'(d), 1);
    req = 2'b00;
    tick();

    // illegal start on requester 1: straight to DONE with err
    start1 = 4'd13; req = 2'b10;
    wait_done(10, n, d, e);
    expect_val("t3_edge", n, 0);
    expect_val("t3_done", 32'(d), 2);
    expect_val("t3_err", 32'(e), 1);
    expect_val("t3_gnt", 32'(gnt), 2);
    req = 2'b00;
    tick();
    tick();

    // abort during the third RUN cycle; rr must stay on requester 0
    start0 = 4'd4; start1 = 4'd3; req = 2'b01;
    tick(); tick(); tick(); tick();
    req = 2'b00;
    tick();
    expect_val("t4_gnt", 32'(gnt), 0);
    expect_val("t4_busy", 32'(busy), 0);
    expect_val("t4_done", 32'(done), 0);
    req = 2'b11;
    tick();
    expect_val("t4_rr_gnt", 32'(gnt), 1);
    req = 2'b00;
    tick(); tick(); tick();

    // frozen counter: watchdog fires after 12 RUN cycles
    stuck = 1; start0 = 4'd2; req = 2'b01;
    wait_done(40, n, d, e);
    expect_val("t5_edge", n, 13);
    expect_val("t5_done", 32'(d), 1);
    expect_val("t5_err", 32'(e), 1);
    req = 2'b00; stuck = 0;
    tick(); tick();

    // asynchronous reset mid-RUN, then rr must restart at requester 0
    start0 = 4'd0; start1 = 4'd0; req = 2'b01;
    tick(); tick(); tick(); tick();
    #3 rst = 1'b0;
    #1;
    expect_val("t6_async_gnt", 32'(gnt), 0);
    expect_val("t6_async_busy", 32'(busy), 0);
    expect_val("t6_async_load", 32'(cnt_load), 0);
    check_outputs("async_rst");
    req = 2'b00;
    tick();
    rst = 1'b1;
    req = 2'b11;
    tick();
    expect_val("t6_gnt_after_rst", 32'(gnt), 1);
    req = 2'b00;
    tick(); tick(); tick();

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t got=running want=finished", $time);
    $fatal(1, "timeout");
  end

endmodule
